// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execute/control stage: widths, opcodes,
// FSM state encoding and instruction field positions.
package exec_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    // Opcodes (instr[15:12]); 0xA-0xE are undefined
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_NOP  = 4'hF;

    // Instruction field bit positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RA_HI  = 8;
    localparam int RA_LO  = 6;
    localparam int RB_HI  = 5;
    localparam int RB_LO  = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MUL  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    // True for ops whose carry flag is rewritten at write-back
    function automatic logic updates_carry(input logic [3:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_ADDI);
    endfunction

endpackage

// File: rtl/exec_ctrl_alu.sv
// Combinational ALU for all single-cycle ops. MUL is handled iteratively
// by the controller, so it produces zero here.
module alu_16bits
    import exec_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [5:0]        imm6,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W:0]   w_sum;

    assign w_imm_ext = {{(DATA_W-6){imm6[5]}}, imm6};

    // Select the result; carry is the extra sum bit (borrow for SUB)
    always_comb begin
        w_sum  = '0;
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_sum  = {1'b0, a} + {1'b0, b};
                result = w_sum[DATA_W-1:0];
                carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_sum  = {1'b0, a} - {1'b0, b};
                result = w_sum[DATA_W-1:0];
                carry  = w_sum[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << b[3:0];
            OP_SHR:  result = a >> b[3:0];
            OP_ADDI: begin
                w_sum  = {1'b0, a} + {1'b0, w_imm_ext};
                result = w_sum[DATA_W-1:0];
                carry  = w_sum[DATA_W];
            end
            OP_MOV:  result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle execute/control stage wrapped around an 8x16 register file.
// IDLE -> READ -> EXEC -> (MUL x16) -> WB -> IDLE, all outputs registered.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic              CLK,
    input  logic              CLR,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_E,
    output logic              done,
    output logic              illegal,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t            r_state;
    logic [15:0]       r_instr;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_carry;

    logic              r_instr_ready;
    logic [ADDR_W-1:0] r_rd_addr_a;
    logic [ADDR_W-1:0] r_rd_addr_b;
    logic [DATA_W-1:0] r_din;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_e;
    logic              r_done;
    logic              r_illegal;
    logic              r_flag_z;
    logic              r_flag_c;
    logic              r_busy;

    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic [DATA_W-1:0] w_acc_next;

    assign w_opcode   = r_instr[OPC_HI:OPC_LO];
    assign w_rd       = r_instr[RD_HI:RD_LO];
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    alu_16bits #(.DATA_W(DATA_W)) u_alu (
        .a      (r_op_a),
        .b      (r_op_b),
        .imm6   (r_instr[IMM_HI:IMM_LO]),
        .opcode (w_opcode),
        .result (w_alu_result),
        .carry  (w_alu_carry)
    );

    // Control FSM: sequences the stage and registers every output
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state       <= S_IDLE;
            r_instr       <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_acc         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_cnt         <= '0;
            r_carry       <= 1'b0;
            r_instr_ready <= 1'b0;
            r_rd_addr_a   <= '0;
            r_rd_addr_b   <= '0;
            r_din         <= '0;
            r_wr_addr     <= '0;
            r_wr_e        <= 1'b0;
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
            r_flag_z      <= 1'b0;
            r_flag_c      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // Pulses default low; each state raises them for one cycle
            r_wr_e    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_instr_ready <= 1'b1;
                    r_busy        <= 1'b0;
                    if (instr_valid && r_instr_ready) begin
                        r_instr       <= instr;
                        r_rd_addr_a   <= instr[RA_HI:RA_LO];
                        r_rd_addr_b   <= instr[RB_HI:RB_LO];
                        r_instr_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_READ;
                    end
                end
                S_READ: begin
                    // Register file outputs are valid for the held addresses
                    r_op_a  <= op_a;
                    r_op_b  <= op_b;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_opcode == OP_MUL) begin
                        r_acc    <= '0;
                        r_mcand  <= r_op_a;
                        r_mplier <= r_op_b;
                        r_cnt    <= '0;
                        r_state  <= S_MUL;
                    end else if (w_opcode > OP_MOV) begin
                        // NOP or undefined opcode: retire without writing
                        r_done        <= 1'b1;
                        r_illegal     <= (w_opcode != OP_NOP);
                        r_instr_ready <= 1'b1;
                        r_busy        <= 1'b0;
                        r_rd_addr_a   <= '0;
                        r_rd_addr_b   <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_din     <= w_alu_result;
                        r_carry   <= w_alu_carry;
                        r_wr_addr <= w_rd;
                        r_wr_e    <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_WB;
                    end
                end
                S_MUL: begin
                    // Shift-add, one multiplier bit per cycle, LSB first
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_din     <= w_acc_next;
                        r_wr_addr <= w_rd;
                        r_wr_e    <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_WB;
                    end
                end
                S_WB: begin
                    // Register file captures din on this edge; flags follow
                    r_flag_z <= (r_din == '0);
                    if (updates_carry(w_opcode)) begin
                        r_flag_c <= r_carry;
                    end
                    r_din         <= '0;
                    r_wr_addr     <= '0;
                    r_rd_addr_a   <= '0;
                    r_rd_addr_b   <= '0;
                    r_instr_ready <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = r_instr_ready;
    assign rd_addr_a   = r_rd_addr_a;
    assign rd_addr_b   = r_rd_addr_b;
    assign din         = r_din;
    assign wr_addr     = r_wr_addr;
    assign wr_E        = r_wr_e;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign flag_z      = r_flag_z;
    assign flag_c      = r_flag_c;
    assign busy        = r_busy;

endmodule
